rat_muldiv_pipe: RTL and testbench

RAT_MULDIV_PIPE -- requirements
Module: rat_muldiv_pipe

---
 rtl/rat_muldiv_pipe.sv | 120 ++++++++++++
 tb/tb_rat_muldiv_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_muldiv_pipe.sv
// Rational multiply/divide with sign-normalized denominator, carried through a
// STAGES-deep valid/ready pipeline whose last stage drives the outputs.
module rat_muldiv_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] l_num,
  input  logic [WIDTH-1:0] l_den,
  input  logic [WIDTH-1:0] r_num,
  input  logic [WIDTH-1:0] r_den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s_num,
  output logic [WIDTH-1:0] s_den,
  output logic             ovf,
  output logic             dz
);

  localparam int PW = 2 * WIDTH;
  localparam int NW = 2 * WIDTH + 1;

  function automatic logic [PW-1:0] sext(input logic [WIDTH-1:0] v);
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction

  // A value fits in WIDTH signed bits when every bit above the sign bit copies it.
  function automatic logic fits(input logic [NW-1:0] v);
    return v[NW-1:WIDTH-1] == {(NW-WIDTH+1){v[WIDTH-1]}};
  endfunction

  logic [WIDTH-1:0] num_mult_s;
  logic [WIDTH-1:0] den_mult_s;
  logic [PW-1:0]    p_num_s;
  logic [PW-1:0]    p_den_s;
  logic [NW-1:0]    x_num_s;
  logic [NW-1:0]    x_den_s;
  logic [NW-1:0]    n_num_s;
  logic [NW-1:0]    n_den_s;
  logic             ovf_s;
  logic             dz_s;
  logic             advance_s;

  logic [STAGES-1:0] valid_r;
  logic [WIDTH-1:0]  num_r [STAGES];
  logic [WIDTH-1:0]  den_r [STAGES];
  logic [STAGES-1:0] ovf_r;
  logic [STAGES-1:0] dz_r;

  // Operand selection, full-precision products and sign normalization.
  always_comb begin
    num_mult_s = r_num;
    den_mult_s = r_den;
    if (op) begin
      num_mult_s = r_den;
      den_mult_s = r_num;
    end else begin
      num_mult_s = r_num;
      den_mult_s = r_den;
    end
    p_num_s = sext(l_num) * sext(num_mult_s);
    p_den_s = sext(l_den) * sext(den_mult_s);
    x_num_s = {p_num_s[PW-1], p_num_s};
    x_den_s = {p_den_s[PW-1], p_den_s};
    if (p_den_s[PW-1]) begin
      n_num_s = ~x_num_s + {{(NW-1){1'b0}}, 1'b1};
      n_den_s = ~x_den_s + {{(NW-1){1'b0}}, 1'b1};
    end else begin
      n_num_s = x_num_s;
      n_den_s = x_den_s;
    end
    ovf_s = ~(fits(n_num_s) & fits(n_den_s));
    dz_s  = (p_den_s == {PW{1'b0}});
  end

  assign advance_s = ~(valid_r[STAGES-1] & ~out_ready);
  assign in_ready  = advance_s;

  // Pipeline stages: shift together unless the last stage is blocked downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {STAGES{1'b0}};
      ovf_r   <= {STAGES{1'b0}};
      dz_r    <= {STAGES{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
        num_r[i] <= {WIDTH{1'b0}};
        den_r[i] <= {WIDTH{1'b0}};
      end
    end else if (advance_s) begin
      valid_r[0] <= in_valid;
      if (in_valid) begin
        num_r[0] <= n_num_s[WIDTH-1:0];
        den_r[0] <= n_den_s[WIDTH-1:0];
        ovf_r[0] <= ovf_s;
        dz_r[0]  <= dz_s;
      end
      // Bubbles move forward but leave the previous payload in place.
      for (int i = 1; i < STAGES; i++) begin
        valid_r[i] <= valid_r[i-1];
        if (valid_r[i-1]) begin
          num_r[i] <= num_r[i-1];
          den_r[i] <= den_r[i-1];
          ovf_r[i] <= ovf_r[i-1];
          dz_r[i]  <= dz_r[i-1];
        end
      end
    end
  end

  assign out_valid = valid_r[STAGES-1];
  assign s_num     = num_r[STAGES-1];
  assign s_den     = den_r[STAGES-1];
  assign ovf       = ovf_r[STAGES-1];
  assign dz        = dz_r[STAGES-1];

endmodule

// File: tb/tb_rat_muldiv_pipe.sv
// Self-checking bench for rat_muldiv_pipe: directed vectors, stall pattern,
// mid-cycle reset and randomized traffic against a plain-arithmetic model.
module tb_rat_muldiv_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op = 1'b0;
  logic [W-1:0] l_num = '0, l_den = '0, r_num = '0, r_den = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s_num, s_den;
  logic         ovf, dz;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic         ovf;
    logic         dz;
  } res_t;

  res_t exp_q[$];

  rat_muldiv_pipe #(.WIDTH(W), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .l_num(l_num), .l_den(l_den), .r_num(r_num), .r_den(r_den),
    .out_valid(out_valid), .out_ready(out_ready),
    .s_num(s_num), .s_den(s_den), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  // Reference: exact products in 64-bit arithmetic, then sign fix-up.
  function automatic res_t model(input logic o, input logic [W-1:0] ln, ld, rn, rd);
    longint pn, pd;
    res_t r;
    if (o) begin
      pn = longint'($signed(ln)) * longint'($signed(rd));
      pd = longint'($signed(ld)) * longint'($signed(rn));
    end else begin
      pn = longint'($signed(ln)) * longint'($signed(rn));
      pd = longint'($signed(ld)) * longint'($signed(rd));
    end
    if (pd < 0) begin
      pn = -pn;
      pd = -pd;
    end
    r.num = pn[W-1:0];
    r.den = pd[W-1:0];
    r.ovf = (pn > 64'sd2147483647) || (pn < -64'sd2147483648) ||
            (pd > 64'sd2147483647) || (pd < -64'sd2147483648);
    r.dz  = (pd == 0);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 6)) - 32'd3;
    return $urandom;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set with out_ready=1 and measure its latency.
  task automatic run_one(input logic o, input logic [W-1:0] ln, ld, rn, rd,
                         output res_t got, output int lat);
    op = o; l_num = ln; l_den = ld; r_num = rn; r_den = rd;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    got = '{num: s_num, den: s_den, ovf: ovf, dz: dz};
    step();
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({out_valid, s_num, s_den, ovf, dz} !== {1'b0, 64'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got v=%0b n=%h d=%h o=%0b z=%0b want all 0",
               out_valid, s_num, s_den, ovf, dz);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
    step();
    rst_n = 1'b1;
    #2;
  endtask

  task automatic test_vectors();
    res_t got;
    int lat;
    logic [W-1:0] n2 = 32'h8000_0000;
    logic [W-1:0] m1 = 32'hFFFF_FFFF;
    logic [W-1:0] m7 = 32'hFFFF_FFF9;
    run_one(1'b0, 32'd3, 32'd4, 32'd5, m7, got, lat);
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL latency: got %0d want 2", lat);
    end
    tests++;
    if (got !== res_t'{num: 32'hFFFF_FFF1, den: 32'd28, ovf: 1'b0, dz: 1'b0}) begin
      fails++;
      $display("FAIL mul_neg_den: got %h want fffffff1/1c/0/0", got);
    end
    run_one(1'b1, 32'd2, 32'd3, 32'd0, 32'd5, got, lat);
    tests++;
    if (got !== res_t'{num: 32'd10, den: 32'd0, ovf: 1'b0, dz: 1'b1}) begin
      fails++;
      $display("FAIL div_by_zero: got %h want a/0/0/1", got);
    end
    run_one(1'b0, 32'h0001_0000, 32'd1, 32'h0001_0000, 32'd1, got, lat);
    tests++;
    if (got !== res_t'{num: 32'd0, den: 32'd1, ovf: 1'b1, dz: 1'b0}) begin
      fails++;
      $display("FAIL mul_overflow: got %h want 0/1/1/0", got);
    end
    run_one(1'b0, n2, 32'd1, 32'd1, m1, got, lat);
    tests++;
    if (got !== res_t'{num: 32'h8000_0000, den: 32'd1, ovf: 1'b1, dz: 1'b0}) begin
      fails++;
      $display("FAIL min_negate: got %h want 80000000/1/1/0", got);
    end
  endtask

  task automatic test_back_to_back();
    int next_in = 1, next_out = 1, c = 0;
    int rcv = 0;
    logic [3:0] pat = 4'b1001;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_num = '0;
    op = 1'b0; l_den = 32'd1; r_num = 32'd1; r_den = 32'd1;
    // Free-flowing phase: one result per cycle, never stalled.
    for (int k = 0; k < 10; k++) begin
      out_ready = 1'b1;
      in_valid  = (k < 8);
      l_num     = W'(k + 1);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL flow_ready: cycle %0d got %0b want 1", k, in_ready);
      end
      if (out_valid) begin
        rcv++;
        tests++;
        if (s_num !== W'(rcv) || k !== rcv + 1) begin
          fails++;
          $display("FAIL flow_order: cycle %0d got %0d want %0d at cycle %0d",
                   k, s_num, rcv, rcv + 1);
        end
      end
      step();
    end
    in_valid = 1'b0;
    // Stall phase: out_ready cycles 1,0,0,1.
    while (next_out <= 8 && c < 80) begin
      out_ready = pat[3 - (c % 4)];
      in_valid  = (next_in <= 8);
      l_num     = W'(next_in);
      #1;
      tests++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        fails++;
        $display("FAIL stall_ready: cycle %0d got %0b want %0b",
                 c, in_ready, !(out_valid && !out_ready));
      end
      if (prev_stall) begin
        tests++;
        if (out_valid !== 1'b1 || s_num !== prev_num) begin
          fails++;
          $display("FAIL stall_hold: cycle %0d got v=%0b n=%0d want v=1 n=%0d",
                   c, out_valid, s_num, prev_num);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (s_num !== W'(next_out) || s_den !== 32'd1 || ovf !== 1'b0) begin
          fails++;
          $display("FAIL stall_order: got %0d/%0d want %0d/1", s_num, s_den, next_out);
        end
        next_out++;
      end
      if (in_valid && in_ready) next_in++;
      prev_stall = out_valid && !out_ready;
      prev_num   = s_num;
      step();
      c++;
    end
    tests++;
    if (next_out !== 9) begin
      fails++;
      $display("FAIL stall_count: got %0d results want 8", next_out - 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_mid_reset();
    op = 1'b0; l_num = 32'd7; l_den = 32'd3; r_num = 32'd1; r_den = 32'd1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, s_num, s_den, ovf, dz} !== {1'b0, 64'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: got v=%0b n=%h d=%h o=%0b z=%0b want all 0",
               out_valid, s_num, s_den, ovf, dz);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset_ready: got %0b want 1", in_ready);
    end
    step();
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL stale_after_reset: cycle %0d got out_valid=%0b want 0", k, out_valid);
      end
    end
  endtask

  task automatic test_random();
    res_t exp_r;
    logic prev_stall = 1'b0;
    res_t prev_out = '0;
    exp_q.delete();
    for (int c = 0; c < 420; c++) begin
      in_valid  = (c < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
      out_ready = (c < 400) ? ($urandom_range(0, 2) != 0) : 1'b1;
      op    = $urandom_range(0, 1);
      l_num = rnd_operand(); l_den = rnd_operand();
      r_num = rnd_operand(); r_den = rnd_operand();
      #1;
      if (prev_stall) begin
        tests++;
        if (out_valid !== 1'b1 || {s_num, s_den, ovf, dz} !== prev_out) begin
          fails++;
          $display("FAIL rand_hold: cycle %0d got %h want %h", c, {s_num, s_den, ovf, dz}, prev_out);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rand_extra: cycle %0d got unexpected result %h want none", c, s_num);
        end else begin
          exp_r = exp_q.pop_front();
          if ({s_num, s_den, ovf, dz} !== exp_r) begin
            fails++;
            $display("FAIL rand_result: cycle %0d got %h want %h",
                     c, {s_num, s_den, ovf, dz}, exp_r);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(op, l_num, l_den, r_num, r_den));
      prev_stall = out_valid && !out_ready;
      prev_out   = {s_num, s_den, ovf, dz};
      step();
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rand_drain: got %0d results missing want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
